// File: rtl/m3_speed_ramp_gen.sv
// Speed-ramp generator for the 3-phase motor driver: holds the commutation period and
// steps it by period>>STEP_SHIFT every ROUNDS qualifying rounds, plus a housekeeping tick.
module m3_speed_ramp_gen #(
    parameter int unsigned PW         = 32,
    parameter int unsigned PERIOD_MAX = 4000000,
    parameter int unsigned PERIOD_MIN = 40,
    parameter int unsigned STEP_SHIFT = 4,
    parameter int unsigned ROUNDS     = 4,
    parameter int unsigned TICK_DIV   = 10000
) (
    input  logic          clkI,
    input  logic          rstI,
    input  logic          workingI,
    input  logic          nextRoundI,
    input  logic          m3speedINCi,
    input  logic          m3speedDECi,
    input  logic          m3forceStopI,
    input  logic          trackModeI,
    input  logic [PW-1:0] targetPeriodI,
    output logic [PW-1:0] periodO,
    output logic          stepO,
    output logic          atMinO,
    output logic          atMaxO,
    output logic          rampingO,
    output logic          stoppedO,
    output logic          tickO
);

    localparam int unsigned RCW = $clog2(ROUNDS) + 1;
    localparam int unsigned TCW = $clog2(TICK_DIV);
    localparam int unsigned WW  = PW + 1;

    localparam logic [PW-1:0]  P_MAX       = PW'(PERIOD_MAX);
    localparam logic [PW-1:0]  P_MIN       = PW'(PERIOD_MIN);
    localparam logic [RCW-1:0] RND_RELOAD  = RCW'(ROUNDS - 1);
    localparam logic [TCW-1:0] TICK_RELOAD = TCW'(TICK_DIV - 1);

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_e;

    logic [PW-1:0]  period_q, period_d;
    logic [RCW-1:0] round_cnt_q, round_cnt_d;
    dir_e           last_dir_q, last_dir_d;
    logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
    logic           step_q, step_d;
    logic           tick_q, tick_d;

    logic [PW-1:0]  tgt;
    logic           req_vld;
    dir_e           req_dir;
    logic           use_trk;
    logic [WW-1:0]  base, delta, diff, sum;
    logic [PW-1:0]  inc_n, dec_n, step_n;

    // Request decode and candidate next period (PW+1 bit arithmetic, never wraps)
    always_comb begin
        tgt     = targetPeriodI;
        req_vld = 1'b0;
        req_dir = DIR_INC;
        use_trk = 1'b0;
        if (targetPeriodI < P_MIN) begin
            tgt = P_MIN;
        end else if (targetPeriodI > P_MAX) begin
            tgt = P_MAX;
        end

        if (m3forceStopI) begin
            req_vld = 1'b1;
            req_dir = DIR_DEC;
        end else if (trackModeI) begin
            use_trk = 1'b1;
            if (period_q < tgt) begin
                req_vld = 1'b1;
                req_dir = DIR_DEC;
            end else if (period_q > tgt) begin
                req_vld = 1'b1;
                req_dir = DIR_INC;
            end
        end else if (m3speedINCi) begin
            req_vld = 1'b1;
            req_dir = DIR_INC;
        end else if (m3speedDECi) begin
            req_vld = 1'b1;
            req_dir = DIR_DEC;
        end

        base  = {1'b0, period_q};
        delta = base >> STEP_SHIFT;
        if (delta == '0) begin
            delta = WW'(1);
        end
        diff = base - delta;
        sum  = base + delta;

        inc_n = diff[PW-1:0];
        if ((delta > base) || (diff < {1'b0, P_MIN})) begin
            inc_n = P_MIN;
        end
        dec_n = sum[PW-1:0];
        if (sum > {1'b0, P_MAX}) begin
            dec_n = P_MAX;
        end

        step_n = (req_dir == DIR_INC) ? inc_n : dec_n;
        // Tracking never overshoots the (clamped) target
        if (use_trk) begin
            if ((req_dir == DIR_INC) && (step_n < tgt)) begin
                step_n = tgt;
            end else if ((req_dir == DIR_DEC) && (step_n > tgt)) begin
                step_n = tgt;
            end
        end
    end

    // Next-state: idle reload, tick divider, round counter and step apply
    always_comb begin
        period_d    = period_q;
        round_cnt_d = round_cnt_q;
        last_dir_d  = last_dir_q;
        tick_cnt_d  = tick_cnt_q;
        step_d      = 1'b0;
        tick_d      = 1'b0;

        if (!workingI) begin
            period_d    = P_MAX;
            round_cnt_d = RND_RELOAD;
            last_dir_d  = DIR_INC;
            tick_cnt_d  = TICK_RELOAD;
        end else begin
            if (tick_cnt_q == '0) begin
                tick_d     = 1'b1;
                tick_cnt_d = TICK_RELOAD;
            end else begin
                tick_cnt_d = tick_cnt_q - TCW'(1);
            end

            if (nextRoundI) begin
                if (!req_vld) begin
                    round_cnt_d = RND_RELOAD;
                end else if (req_dir != last_dir_q) begin
                    round_cnt_d = RND_RELOAD;
                    last_dir_d  = req_dir;
                end else if (round_cnt_q != '0) begin
                    round_cnt_d = round_cnt_q - RCW'(1);
                end else begin
                    round_cnt_d = RND_RELOAD;
                    period_d    = step_n;
                    step_d      = (step_n != period_q);
                end
            end
        end
    end

    always_ff @(posedge clkI) begin
        if (rstI) begin
            period_q    <= P_MAX;
            round_cnt_q <= RND_RELOAD;
            last_dir_q  <= DIR_INC;
            tick_cnt_q  <= TICK_RELOAD;
            step_q      <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            period_q    <= period_d;
            round_cnt_q <= round_cnt_d;
            last_dir_q  <= last_dir_d;
            tick_cnt_q  <= tick_cnt_d;
            step_q      <= step_d;
            tick_q      <= tick_d;
        end
    end

    assign periodO  = period_q;
    assign stepO    = step_q;
    assign tickO    = tick_q;
    assign atMinO   = (period_q == P_MIN);
    assign atMaxO   = (period_q == P_MAX);
    assign stoppedO = m3forceStopI && (period_q == P_MAX);
    assign rampingO = workingI && req_vld && (step_n != period_q);

endmodule

// File: tb/tb_m3_speed_ramp_gen.sv
// Scoreboard bench for m3_speed_ramp_gen: default instance plus a small 8-bit instance
// for the step-floor and no-wrap cap boundaries.
module tb_m3_speed_ramp_gen;

    localparam longint P_MAX = 4000000;
    localparam longint P_MIN = 40;

    typedef struct {
        int     inst;
        longint period;
        bit     step;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        working = 1'b0;
    logic        next_round = 1'b0;
    logic        inc = 1'b0, dec = 1'b0, fstop = 1'b0, track = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] period;
    logic        step, at_min, at_max, ramping, stopped, tick;

    logic        s_next_round = 1'b0, s_inc = 1'b0, s_dec = 1'b0;
    logic [7:0]  s_period;
    logic        s_step, s_at_min, s_at_max, s_ramping, s_stopped, s_tick;

    int n_pass  = 0;
    int n_total = 0;

    exp_t   sb[$];
    longint m_per[2];
    int     m_cnt[2];
    bit     m_last[2];
    longint c_max[2] = '{4000000, 250};
    longint c_min[2] = '{40, 1};
    int     c_sh[2]  = '{4, 4};
    int     c_rnd[2] = '{4, 1};

    always #5 clk = ~clk;

    m3_speed_ramp_gen dut (
        .clkI(clk), .rstI(rst), .workingI(working), .nextRoundI(next_round),
        .m3speedINCi(inc), .m3speedDECi(dec), .m3forceStopI(fstop), .trackModeI(track),
        .targetPeriodI(target), .periodO(period), .stepO(step), .atMinO(at_min),
        .atMaxO(at_max), .rampingO(ramping), .stoppedO(stopped), .tickO(tick)
    );

    m3_speed_ramp_gen #(
        .PW(8), .PERIOD_MAX(250), .PERIOD_MIN(1), .STEP_SHIFT(4), .ROUNDS(1), .TICK_DIV(4)
    ) dut_s (
        .clkI(clk), .rstI(rst), .workingI(working), .nextRoundI(s_next_round),
        .m3speedINCi(s_inc), .m3speedDECi(s_dec), .m3forceStopI(1'b0), .trackModeI(1'b0),
        .targetPeriodI(8'd0), .periodO(s_period), .stepO(s_step), .atMinO(s_at_min),
        .atMaxO(s_at_max), .rampingO(s_ramping), .stoppedO(s_stopped), .tickO(s_tick)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_per[k]  = c_max[k];
            m_cnt[k]  = c_rnd[k] - 1;
            m_last[k] = 1'b0;
        end
        sb.delete();
    endtask

    // Reference behaviour of one nextRoundI pulse; pushes the expected result
    task automatic model_round(input int k, input bit i, input bit dc, input bit fs,
                               input bit trk, input longint tg_raw);
        longint p, tg, n, d;
        bit     v, dir, stp;
        exp_t   e;
        p   = m_per[k];
        v   = 1'b0;
        dir = 1'b0;
        stp = 1'b0;
        tg  = tg_raw;
        if (tg < c_min[k]) tg = c_min[k];
        if (tg > c_max[k]) tg = c_max[k];
        if (fs) begin
            v = 1'b1; dir = 1'b1;
        end else if (trk) begin
            if (p < tg) begin v = 1'b1; dir = 1'b1; end
            else if (p > tg) begin v = 1'b1; dir = 1'b0; end
        end else if (i) begin
            v = 1'b1; dir = 1'b0;
        end else if (dc) begin
            v = 1'b1; dir = 1'b1;
        end

        if (!v) begin
            m_cnt[k] = c_rnd[k] - 1;
        end else if (dir != m_last[k]) begin
            m_cnt[k]  = c_rnd[k] - 1;
            m_last[k] = dir;
        end else if (m_cnt[k] > 0) begin
            m_cnt[k]--;
        end else begin
            m_cnt[k] = c_rnd[k] - 1;
            d = p >> c_sh[k];
            if (d == 0) d = 1;
            if (dir) begin
                n = p + d;
                if (n > c_max[k]) n = c_max[k];
                if (trk && !fs && n > tg) n = tg;
            end else begin
                n = p - d;
                if (n < c_min[k]) n = c_min[k];
                if (trk && !fs && n < tg) n = tg;
            end
            stp      = (n != p);
            m_per[k] = n;
        end
        e.inst   = k;
        e.period = m_per[k];
        e.step   = stp;
        sb.push_back(e);
    endtask

    task automatic do_round(input int k, input bit i, input bit dc, input bit fs,
                            input bit trk, input longint tg);
        exp_t e;
        @(negedge clk);
        if (k == 0) begin
            inc = i; dec = dc; fstop = fs; track = trk; target = 32'(tg);
            next_round = 1'b1;
        end else begin
            s_inc = i; s_dec = dc;
            s_next_round = 1'b1;
        end
        model_round(k, i, dc, fs, trk, tg);
        @(negedge clk);
        next_round   = 1'b0;
        s_next_round = 1'b0;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            if (e.inst == 0) begin
                check("period", longint'(period), e.period);
                check("step", longint'(step), longint'(e.step));
                check("stopped", longint'(stopped), longint'(fs && (e.period == P_MAX)));
            end else begin
                check("s_period", longint'(s_period), e.period);
                check("s_step", longint'(s_step), longint'(e.step));
            end
        end
    endtask

    task automatic clear_inputs();
        inc = 1'b0; dec = 1'b0; fstop = 1'b0; track = 1'b0; target = '0;
        s_inc = 1'b0; s_dec = 1'b0;
    endtask

    task automatic reset_all();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        working = 1'b1;
        reset_all();

        // Reset state
        check("rst_period", longint'(period), P_MAX);
        check("rst_atmax", longint'(at_max), 1);
        check("rst_atmin", longint'(at_min), 0);
        check("rst_step", longint'(step), 0);
        check("rst_tick", longint'(tick), 0);
        check("rst_ramping", longint'(ramping), 0);
        check("rst_stopped", longint'(stopped), 0);

        // INC held down to PERIOD_MIN
        for (int r = 0; r < 4; r++) do_round(0, 1, 0, 0, 0, 0);
        check("inc_first", longint'(period), 3750000);
        check("ramping_mid", longint'(ramping), 1);
        for (int r = 0; r < 3000 && m_per[0] != P_MIN; r++) do_round(0, 1, 0, 0, 0, 0);
        for (int r = 0; r < 8; r++) do_round(0, 1, 0, 0, 0, 0);
        check("min_period", longint'(period), P_MIN);
        check("min_atmin", longint'(at_min), 1);
        check("min_ramping", longint'(ramping), 0);

        // Force stop with INC still held ramps back to PERIOD_MAX
        for (int r = 0; r < 3000 && m_per[0] != P_MAX; r++) do_round(0, 1, 0, 1, 0, 0);
        for (int r = 0; r < 4; r++) do_round(0, 1, 0, 1, 0, 0);
        check("fs_period", longint'(period), P_MAX);
        check("fs_atmax", longint'(at_max), 1);
        check("fs_ramping", longint'(ramping), 0);

        // INC then DEC: switch round reloads, DEC step after 4 more rounds
        reset_all();
        for (int r = 0; r < 4; r++) do_round(0, 1, 0, 0, 0, 0);
        for (int r = 0; r < 3; r++) do_round(0, 1, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++) do_round(0, 0, 1, 0, 0, 0);
        check("dec_pending", longint'(period), 3750000);
        do_round(0, 0, 1, 0, 0, 0);
        check("dec_first", longint'(period), 3984375);

        // Target tracking with clamp to target, then out-of-range target
        reset_all();
        for (int r = 0; r < 20; r++) do_round(0, 0, 0, 0, 1, 3700000);
        check("trk_period", longint'(period), 3700000);
        check("trk_ramping", longint'(ramping), 0);
        for (int r = 0; r < 3000 && m_per[0] != P_MIN; r++) do_round(0, 0, 0, 0, 1, 10);
        for (int r = 0; r < 6; r++) do_round(0, 0, 0, 0, 1, 10);
        check("trk_low_period", longint'(period), P_MIN);

        // Reset mid-ramp
        reset_all();
        for (int r = 0; r < 6; r++) do_round(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midrst_period", longint'(period), P_MAX);
        for (int r = 0; r < 4; r++) do_round(0, 1, 0, 0, 0, 0);
        check("midrst_reload", longint'(period), 3750000);

        // workingI low mid-ramp, then tick spacing
        for (int r = 0; r < 2; r++) do_round(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        clear_inputs();
        working = 1'b0;
        @(negedge clk);
        model_reset();
        check("idle_period", longint'(period), P_MAX);
        check("idle_tick", longint'(tick), 0);
        working = 1'b1;
        cnt = 0;
        for (int c = 1; c <= 10100; c++) begin
            @(negedge clk);
            if (tick) begin cnt = c; break; end
        end
        check("tick_first", cnt, 10000);
        cnt = 0;
        for (int c = 1; c <= 10100; c++) begin
            @(negedge clk);
            if (tick) begin cnt = c; break; end
        end
        check("tick_second", cnt, 10000);
        for (int r = 0; r < 4; r++) do_round(0, 1, 0, 0, 0, 0);
        check("idle_reload", longint'(period), 3750000);

        // Small instance: step floor of 1 down to PERIOD_MIN=1, capped ramp up to 250
        reset_all();
        check("s_rst_period", longint'(s_period), 250);
        for (int r = 0; r < 400 && m_per[1] != 1; r++) do_round(1, 1, 0, 0, 0, 0);
        for (int r = 0; r < 2; r++) do_round(1, 1, 0, 0, 0, 0);
        check("s_min", longint'(s_period), 1);
        check("s_atmin", longint'(s_at_min), 1);
        for (int r = 0; r < 400 && m_per[1] != 250; r++) do_round(1, 0, 1, 0, 0, 0);
        for (int r = 0; r < 2; r++) do_round(1, 0, 1, 0, 0, 0);
        check("s_max", longint'(s_period), 250);
        check("s_atmax", longint'(s_at_max), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
